// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its neighbours.
// Holds the FSM state encoding, the default timing constants and the parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_t;

    localparam int unsigned DEF_INHIBIT_CYCLES = 32'd5000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd750000;

    // The PS/2 frame uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a PS/2 command source and the host transmitter.
// The master offers a byte and watches the completion pulses.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       error;

    modport master (output tx_data, output tx_valid,
                    input  tx_ready, input busy, input done, input error);
    modport slave  (input  tx_data, input tx_valid,
                    output tx_ready, output busy, output done, output error);
endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for one raw PS/2 line plus a falling-edge strobe.
// Resets to the idle-high bus level so leaving reset never fakes an edge.
module ps2_sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic i_pin,
    output logic o_sync,
    output logic o_fe
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    // Synchroniser chain and previous-value register for edge detection.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_s1   <= i_pin;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_sync = r_s2;
    assign o_fe   = r_prev & ~r_s2;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 10 bits
// clocked by the device, then ACK check, with an overall transaction timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic          clock,
    input  logic          reset_n,
    ps2_host_tx_if.slave  bus,
    input  logic          ps2_clk_i,
    input  logic          ps2_dat_i,
    output logic          ps2_clk_oe,
    output logic          ps2_dat_oe
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int          CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] INH_DAT  = CNT_W'(INHIBIT_CYCLES - 32'd2);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 32'd1);

    ps2_state_t       r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [9:0]       r_shreg, w_shreg;
    logic [3:0]       r_bitcnt, w_bitcnt;
    logic             r_clk_oe, w_clk_oe;
    logic             r_dat_oe, w_dat_oe;
    logic             r_done, w_done;
    logic             r_error, w_error;
    logic             r_ready, w_ready;
    logic             w_clk_sync, w_clk_fe, w_dat_sync, w_dat_fe_unused, w_timeout;

    ps2_sync_edge u_clk_sync (.clock(clock), .reset_n(reset_n), .i_pin(ps2_clk_i),
                              .o_sync(w_clk_sync), .o_fe(w_clk_fe));
    ps2_sync_edge u_dat_sync (.clock(clock), .reset_n(reset_n), .i_pin(ps2_dat_i),
                              .o_sync(w_dat_sync), .o_fe(w_dat_fe_unused));

    assign w_timeout = (r_cnt == TO_LAST);

    // Next-state, line-drive and pulse logic; the last INHIBIT cycle already drives the start bit.
    always_comb begin
        w_state  = r_state;
        w_cnt    = (&r_cnt) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        w_shreg  = r_shreg;
        w_bitcnt = r_bitcnt;
        w_clk_oe = r_clk_oe;
        w_dat_oe = r_dat_oe;
        w_done   = 1'b0;
        w_error  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt    = '0;
                w_clk_oe = 1'b0;
                w_dat_oe = 1'b0;
                if (bus.tx_valid && r_ready) begin
                    w_shreg  = {1'b1, odd_parity(bus.tx_data), bus.tx_data};
                    w_bitcnt = 4'd0;
                    w_clk_oe = 1'b1;
                    w_state  = INHIBIT;
                end else begin
                    w_state  = IDLE;
                end
            end
            INHIBIT: begin
                if (r_cnt == INH_LAST) begin
                    w_state  = REQ;
                    w_clk_oe = 1'b0;
                    w_dat_oe = 1'b1;
                    w_cnt    = '0;
                end else if (r_cnt == INH_DAT) begin
                    w_dat_oe = 1'b1;
                end else begin
                    w_dat_oe = 1'b0;
                end
            end
            REQ: begin
                if (w_timeout) begin
                    w_error = 1'b1;
                end else if (w_clk_fe) begin
                    w_dat_oe = ~r_shreg[0];
                    w_bitcnt = 4'd0;
                    w_state  = SEND;
                end else begin
                    w_state  = REQ;
                end
            end
            SEND: begin
                if (w_timeout) begin
                    w_error = 1'b1;
                end else if (w_clk_fe) begin
                    w_shreg  = {1'b1, r_shreg[9:1]};
                    w_dat_oe = ~r_shreg[1];
                    w_bitcnt = r_bitcnt + 4'd1;
                    w_state  = (r_bitcnt == 4'd8) ? ACK : SEND;
                end else begin
                    w_state  = SEND;
                end
            end
            ACK: begin
                w_dat_oe = 1'b0;
                if (w_clk_fe) begin
                    if (!w_dat_sync) begin
                        w_state = WAIT_IDLE;
                    end else begin
                        w_error = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_error = 1'b1;
                end else begin
                    w_state = ACK;
                end
            end
            WAIT_IDLE: begin
                if (w_clk_sync && w_dat_sync) begin
                    w_done  = 1'b1;
                    w_state = IDLE;
                end else if (w_timeout) begin
                    w_error = 1'b1;
                end else begin
                    w_state = WAIT_IDLE;
                end
            end
            default: begin
                w_state  = IDLE;
                w_clk_oe = 1'b0;
                w_dat_oe = 1'b0;
            end
        endcase
        // Any error aborts the frame and frees both lines on the same edge.
        if (w_error) begin
            w_state  = IDLE;
            w_clk_oe = 1'b0;
            w_dat_oe = 1'b0;
        end else begin
            w_state  = w_state;
        end
        w_ready = (w_state == IDLE) && !w_done && !w_error;
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_shreg  <= 10'd0;
            r_bitcnt <= 4'd0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_shreg  <= w_shreg;
            r_bitcnt <= w_bitcnt;
            r_clk_oe <= w_clk_oe;
            r_dat_oe <= w_dat_oe;
            r_done   <= w_done;
            r_error  <= w_error;
            r_ready  <= w_ready;
        end
    end

    assign bus.tx_ready = r_ready;
    assign bus.busy     = ~r_ready;
    assign bus.done     = r_done;
    assign bus.error    = r_error;
    assign ps2_clk_oe   = r_clk_oe;
    assign ps2_dat_oe   = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on open-collector lines.
// Expected wire bits, pulse counts and latencies are written out by hand per step.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 50;
    localparam int TO  = 2000;
    localparam int H   = 40;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic ps2_clk_i, ps2_dat_i, ps2_clk_oe, ps2_dat_oe;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    int   n_assert = 0, n_fail = 0, n_done = 0, n_err = 0, n_both = 0;
    int   d0, e0, t;
    logic [10:0] bits;

    assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx_if bus();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus),
        .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
    );

    always #10 clock = ~clock;

    always @(posedge clock) begin
        #1;
        if (bus.done === 1'b1) n_done++;
        if (bus.error === 1'b1) n_err++;
        if (bus.done === 1'b1 && bus.error === 1'b1) n_both++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [7:0] d);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        ticks(1);
        bus.tx_valid = 1'b0;
    endtask

    // Device side: waits for request, clocks n_clk pulses, captures start..stop bits.
    task automatic dev_transfer(input int n_clk, input bit ack, input bit poke, output logic [10:0] b);
        int w, hi, ov;
        b = 11'd0;
        w = 0;
        while (ps2_clk_oe !== 1'b1 && w < 1000) begin ticks(1); w++; end
        hi = 0; ov = 0;
        while (ps2_clk_oe === 1'b1 && hi < 10000) begin
            if (ps2_dat_oe === 1'b1) ov++;
            ticks(1);
            hi++;
        end
        chk("inhibit_len", hi, INH);
        chk("req_overlap", ov, 1);
        b[0] = ps2_dat_i;
        ticks(H);
        for (int i = 0; i < n_clk && i < 11; i++) begin
            if (i == 10 && ack) begin dev_dat_low = 1'b1; ticks(5); end
            dev_clk_low = 1'b1;
            if (poke && i == 3) begin
                bus.tx_data = 8'h00; bus.tx_valid = 1'b1; ticks(1);
                bus.tx_valid = 1'b0; ticks(H - 1);
            end else begin
                ticks(H);
            end
            if (i < 10) b[i + 1] = ps2_dat_i;
            dev_clk_low = 1'b0;
            ticks(H);
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        int w;
        w = 0;
        while (bus.done !== 1'b1 && bus.error !== 1'b1 && w < 200) begin ticks(1); w++; end
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_ready_in_pulse"}, bus.tx_ready, 0);
        ticks(1);
        chk({tag, "_ready_after"}, bus.tx_ready, 1);
        chk({tag, "_busy_after"}, bus.busy, 0);
    endtask

    initial begin
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        ticks(3);
        chk("rst_ready", bus.tx_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        reset_n = 1'b1;
        ticks(3);

        // 0xED: six ones, parity 1.
        d0 = n_done; e0 = n_err;
        send_req(8'hED);
        chk("busy_after_accept", bus.busy, 1);
        dev_transfer(11, 1'b1, 1'b0, bits);
        chk("bits_ED", bits, 11'b1_1_11101101_0);
        expect_done("ED");
        chk("ED_done_count", n_done - d0, 1);
        chk("ED_err_count", n_err - e0, 0);

        // 0xF4: five ones, parity 0.
        d0 = n_done;
        send_req(8'hF4);
        dev_transfer(11, 1'b1, 1'b0, bits);
        chk("bits_F4", bits, 11'b1_0_11110100_0);
        chk("F4_parity", bits[9], 0);
        expect_done("F4");
        chk("F4_done_count", n_done - d0, 1);

        // Silent device: error exactly TO cycles after CLK release.
        d0 = n_done; e0 = n_err;
        send_req(8'h55);
        t = 0;
        while (ps2_clk_oe === 1'b1 && t < 10000) begin ticks(1); t++; end
        t = 0;
        while (bus.error !== 1'b1 && t < TO + 100) begin ticks(1); t++; end
        chk("timeout_latency", t, TO);
        chk("timeout_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        ticks(1);
        chk("timeout_ready_after", bus.tx_ready, 1);
        chk("timeout_counts", {n_done - d0, n_err - e0}, {32'd0, 32'd1});

        // Missing ACK: DATA left high on the 11th clock.
        d0 = n_done; e0 = n_err;
        send_req(8'h3C);
        dev_transfer(11, 1'b0, 1'b0, bits);
        ticks(5);
        chk("noack_err_count", n_err - e0, 1);
        chk("noack_done_count", n_done - d0, 0);
        chk("noack_idle", bus.tx_ready, 1);

        // Reset after four data bits.
        d0 = n_done; e0 = n_err;
        send_req(8'hA5);
        dev_transfer(4, 1'b0, 1'b0, bits);
        chk("mid_busy", bus.busy, 1);
        reset_n = 1'b0;
        ticks(1);
        chk("mid_rst_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        chk("mid_rst_ready", bus.tx_ready, 1);
        reset_n = 1'b1;
        ticks(5);
        chk("mid_rst_pulses", {n_done - d0, n_err - e0}, {32'd0, 32'd0});
        send_req(8'hFF);
        dev_transfer(11, 1'b1, 1'b0, bits);
        chk("bits_FF", bits, 11'b1_1_11111111_0);
        expect_done("FF");

        // tx_valid with 0x00 while busy must not alter or queue anything.
        d0 = n_done;
        send_req(8'hED);
        dev_transfer(11, 1'b1, 1'b1, bits);
        chk("bits_ED_poked", bits, 11'b1_1_11101101_0);
        expect_done("poke");
        ticks(INH);
        chk("no_queued_xfer", ps2_clk_oe, 0);
        chk("poke_done_count", n_done - d0, 1);
        chk("never_both", n_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter for the keyboard/mouse port. Sends one command byte to the device (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) using the standard request-to-send sequence, odd parity and device acknowledge. Drives open-collector PS2_CLK/PS2_DAT through output-enable signals; the top level ties each pin low when its enable is 1, else 'z'. Runs on clock_50 beside the PS/2 scan-code receiver and shares the same pins.

Parameters:
INHIBIT_CYCLES, 5000, clock cycles CLK held low before request (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, max cycles from CLK release to ACK before error (15 ms at 50 MHz)

Ports:
clock  in  1  system clock (clock_50)
reset_n  in  1  synchronous active-low reset
tx_data  in  8  byte to send
tx_valid  in  1  start request; accepted when tx_ready=1
tx_ready  out  1  1 in IDLE only
busy  out  1  1 in any state except IDLE
done  out  1  one-cycle pulse on successful ACK and bus idle
error  out  1  one-cycle pulse on timeout or missing ACK
ps2_clk_i  in  1  raw PS2_CLK pin level (asynchronous)
ps2_dat_i  in  1  raw PS2_DAT pin level (asynchronous)
ps2_clk_oe  out  1  1 = pull PS2_CLK low
ps2_dat_oe  out  1  1 = pull PS2_DAT low

Behaviour:
- Reset (reset_n=0 at clock edge): state IDLE, ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1, busy=0, done=0, error=0, counters 0. Reset mid-transfer releases both lines on that same edge; no done/error pulse.
- Inputs pass through 2-FF synchronisers. Falling-edge strobe fe = sync_prev & ~sync_now. Sync-to-fe latency: 3 cycles.
- Shift register holds {stop=1, parity=~^tx_data, tx_data}. Bit sent = shreg[0]. ps2_dat_oe = ~bit, so 1 releases the line.
- IDLE: tx_valid & tx_ready latches tx_data, clears cnt, goes to INHIBIT. tx_valid in any other state is ignored, not queued.
- INHIBIT: clk_oe=1, dat_oe=0. After INHIBIT_CYCLES cycles go to REQ with dat_oe=1 (start bit), i.e. data pulled low while CLK still low for 1 cycle.
- REQ: clk_oe=0, dat_oe=1. cnt counts from 0. On the first fe, present bit0 and go to SEND with bitcnt=0.
- SEND: each fe shifts to the next bit: edges 2..8 give data bits 1..7, edge 9 gives parity, edge 10 gives stop (dat_oe=0). After the stop edge go to ACK.
- ACK: on the next fe sample ps2_dat_sync. If 0, go to WAIT_IDLE. If 1, pulse error and go to IDLE.
- WAIT_IDLE: wait until clk_sync=1 and dat_sync=1, then pulse done and go to IDLE.
- Timeout: cnt runs in REQ, SEND, ACK and WAIT_IDLE. When cnt reaches TIMEOUT_CYCLES-1: pulse error, release both lines, go to IDLE. If timeout and ACK/done occur in the same cycle, ACK/done wins.
- done and error are never 1 in the same cycle. tx_ready returns to 1 in the cycle after done or error.
- Counter width is $clog2(max(INHIBIT_CYCLES,TIMEOUT_CYCLES))+1 and saturates rather than wrapping.

Decomposition:
- Package ps2_pkg: state enum (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE), default cycle constants, and the function odd_parity(byte) = ~^byte.
- Sub-module ps2_sync_edge: 2-FF synchroniser plus falling-edge strobe, one per line. The scan-code receiver reuses it.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz: CLK low for 5000 cycles, then bits 1,0,1,1,0,1,1,1, parity 1, stop 1, device ACK low -> done pulse once, tx_ready=1.
- Send 0xF4 (5 ones) -> parity bit 0 on edge 9, done asserted.
- No device clocks after request -> error pulse exactly TIMEOUT_CYCLES cycles after CLK release; both oe=0 afterwards.
- Device leaves DATA high at the ACK edge -> error pulse, no done, IDLE.
- reset_n low after 4 data bits -> next edge clk_oe=0, dat_oe=0, tx_ready=1, no pulses; a new 0xFF transfer then completes normally.
- tx_valid pulsed with 0x00 during a busy transfer of 0xED -> ignored; the bit sequence on the wire stays that of 0xED.
